// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad matrix scanner.
// Included by the interface, the scan divider and the scanner top.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    DB_RELEASE
  } key_state_t;

  // One frame's outcome: a key code, or the "none" flag when no key was seen.
  typedef struct packed {
    logic                none;
    logic [KEY_BITS-1:0] code;
  } frame_res_t;

  localparam frame_res_t NO_KEY = '{none: 1'b1, code: '0};

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Pin-side matrix signals and the key event outputs of the keypad scanner.
// The master modport is the scanner; the slave modport is the board/consumer side.
interface keypad_matrix_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_n;
  logic [NUM_COLS-1:0] col_n;
  logic [KEY_BITS-1:0] key_code;
  logic                key_valid;
  logic                key_down;

  modport master (
    input  row_n,
    output col_n, key_code, key_valid, key_down
  );

  modport slave (
    output row_n,
    input  col_n, key_code, key_valid, key_down
  );

endinterface

// File: rtl/keypad_scan_divider.sv
// Column-rate divider: counts 0..SCAN_DIV-1 and emits a scan tick on the
// terminal count, advancing the column index on that same tick.
module keypad_scan_divider
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50_000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_tick,
  output logic [$clog2(NUM_COLS)-1:0] o_col
);

  localparam int                CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]            r_count;
  logic [$clog2(NUM_COLS)-1:0] r_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_col   <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
      r_col   <= r_col + 1'b1;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = (r_count == LAST);
  assign o_col  = r_col;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner with frame-based debounce and key event outputs.
// Optional auto-repeat of key_valid while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_FRAMES = 50
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  keypad_matrix_scanner_if.master  bus
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] r_sync1, r_sync2;
  logic [NUM_COLS-1:0] r_col_n;
  logic                w_tick;
  logic [1:0]          w_col;
  logic                w_row_hit;
  logic [1:0]          w_row;
  frame_res_t          w_col_res, w_frame_res, r_acc;
  logic                w_frame_end;
  logic                w_cand_here;

  key_state_t          r_state;
  logic [KEY_BITS-1:0] r_cand;
  logic [3:0]          r_cnt;
  logic [KEY_BITS-1:0] r_key_code;
  logic                r_key_valid;
  logic                r_key_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.row_n;
      r_sync2 <= r_sync1;
    end
  end

  keypad_scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick),
    .o_col  (w_col)
  );

  // Lowest-numbered active row wins within a column.
  always_comb begin
    w_row_hit = 1'b0;
    w_row     = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!r_sync2[r]) begin
        w_row_hit = 1'b1;
        w_row     = 2'(r);
      end
    end
  end

  always_comb begin
    w_col_res = w_row_hit ? '{none: 1'b0, code: {w_row, w_col}} : NO_KEY;
    if (w_col == 2'd0)
      w_frame_res = w_col_res;
    else if (!r_acc.none)
      w_frame_res = r_acc;
    else
      w_frame_res = w_col_res;
  end

  assign w_frame_end = w_tick && (w_col == 2'd3);
  assign w_cand_here = !w_frame_res.none && (w_frame_res.code == r_cand);

  // Column drive is registered so the pins never see decoder glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= NO_KEY;
      r_col_n <= 4'b1110;
    end else if (w_tick) begin
      r_acc   <= w_frame_res;
      r_col_n <= ~(4'b0001 << (w_col + 2'd1));
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int             REP_W    = $clog2(REPEAT_FRAMES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_FRAMES);
  logic [REP_W-1:0] r_rep;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= '0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      if (w_frame_end) begin
        case (r_state)
          IDLE: begin
            if (!w_frame_res.none) begin
              r_cand <= w_frame_res.code;
              r_cnt  <= 4'd1;
              if (DB_N <= 4'd1) begin
                r_state     <= PRESSED;
                r_key_code  <= w_frame_res.code;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                r_rep       <= '0;
`endif
              end else begin
                r_state <= DB_PRESS;
              end
            end
          end
          DB_PRESS: begin
            if (w_frame_res.none) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (w_cand_here) begin
              r_cnt <= r_cnt + 4'd1;
              if (r_cnt + 4'd1 >= DB_N) begin
                r_state     <= PRESSED;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                r_rep       <= '0;
`endif
              end
            end else begin
              r_cand <= w_frame_res.code;
              r_cnt  <= 4'd1;
            end
          end
          PRESSED: begin
            if (w_cand_here) begin
`ifdef KEYPAD_REPEAT_EN
              if (r_rep + 1'b1 == REP_LAST) begin
                r_rep       <= '0;
                r_key_valid <= 1'b1;
              end else begin
                r_rep <= r_rep + 1'b1;
              end
`endif
            end else if (DB_N <= 4'd1) begin
              r_state    <= IDLE;
              r_cnt      <= '0;
              r_key_down <= 1'b0;
            end else begin
              r_state <= DB_RELEASE;
              r_cnt   <= 4'd1;
            end
          end
          DB_RELEASE: begin
            if (w_cand_here) begin
              r_state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
              r_rep   <= '0;
`endif
            end else if (r_cnt + 4'd1 >= DB_N) begin
              r_state    <= IDLE;
              r_cnt      <= '0;
              r_key_down <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.col_n     = r_col_n;
  assign bus.key_code  = r_key_code;
  assign bus.key_valid = r_key_valid;
  assign bus.key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner: frame-level key model drives the
// matrix, a behavioural reference predicts every cycle's outputs. Honours KEYPAD_REPEAT_EN.
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV  = 4;
  localparam int DB        = 3;
  localparam int FRAME_LEN = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam int RF        = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_matrix_scanner_if bus ();

  keypad_matrix_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DB)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_FRAMES (RF)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Physical matrix: a pressed key shorts its row to its column.
  logic [15:0] keysHeld = '0;
  logic [3:0]  rowDrive;
  always_comb begin
    rowDrive = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!bus.col_n[c] && keysHeld[r*4+c]) rowDrive[r] = 1'b0;
  end
  assign bus.row_n = rowDrive;

  int cmpCount = 0;
  int errCount = 0;
  int cycleN   = 0;

  // Reference model state, kept at the level of whole frames.
  bit modelDown;
  int modelCode;
  int runCode, runLen, absentRun, repCount;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    cmpCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycleN);
    end
  endtask

  function automatic int frameCode(input logic [15:0] mask);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[r*4+c]) return r * 4 + c;
    return -1;
  endfunction

  task automatic modelReset();
    modelDown = 0; modelCode = 0;
    runCode = -1; runLen = 0; absentRun = 0; repCount = 0;
  endtask

  task automatic modelFrame(input int f, output bit strobe);
    strobe = 0;
    if (!modelDown) begin
      if (f < 0) begin runCode = -1; runLen = 0; end
      else if (f == runCode) runLen++;
      else begin runCode = f; runLen = 1; end
      if (f >= 0 && runLen >= DB) begin
        modelDown = 1; modelCode = f; strobe = 1;
        runCode = -1; runLen = 0; absentRun = 0; repCount = 0;
      end
    end else if (f == modelCode) begin
      if (absentRun > 0) begin
        absentRun = 0; repCount = 0;
      end else begin
`ifdef KEYPAD_REPEAT_EN
        repCount++;
        if (repCount == RF) begin strobe = 1; repCount = 0; end
`endif
      end
    end else begin
      absentRun++;
      if (absentRun >= DB) begin modelDown = 0; absentRun = 0; end
    end
  endtask

  // Holds one key mask for a whole frame and checks every cycle of it.
  task automatic applyStimulus(input logic [15:0] mask);
    bit prevDown, strobe;
    int prevCode;
    logic [3:0] expCol;
    keysHeld = mask;
    prevDown = modelDown;
    prevCode = modelCode;
    modelFrame(frameCode(mask), strobe);
    for (int i = 0; i < FRAME_LEN; i++) begin
      @(posedge clk);
      cycleN++;
      @(negedge clk);
      expCol = ~(4'b0001 << ((cycleN / SCAN_DIV) % 4));
      checkOutput("col_n", 16'(bus.col_n), 16'(expCol));
      if (i == FRAME_LEN - 1) begin
        checkOutput("key_valid", 16'(bus.key_valid), 16'(strobe));
        checkOutput("key_down", 16'(bus.key_down), 16'(modelDown));
        checkOutput("key_code", 16'(bus.key_code), 16'(modelCode));
      end else begin
        checkOutput("key_valid", 16'(bus.key_valid), 16'h0);
        checkOutput("key_down", 16'(bus.key_down), 16'(prevDown));
        checkOutput("key_code", 16'(bus.key_code), 16'(prevCode));
      end
    end
  endtask

  task automatic holdFrames(input logic [15:0] mask, input int n);
    for (int k = 0; k < n; k++) applyStimulus(mask);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_col_n"}, 16'(bus.col_n), 16'hE);
    checkOutput({tag, "_key_valid"}, 16'(bus.key_valid), 16'h0);
    checkOutput({tag, "_key_down"}, 16'(bus.key_down), 16'h0);
    checkOutput({tag, "_key_code"}, 16'(bus.key_code), 16'h0);
  endtask

  logic [15:0] k9, k5, k6and3;
  logic [15:0] prevMask, nextMask;

  initial begin
    k9     = 16'h0001 << 9;
    k5     = 16'h0001 << 5;
    k6and3 = (16'h0001 << 6) | (16'h0001 << 3);
    modelReset();
    repeat (2) @(negedge clk);
    checkResetValues("in_reset");
    rst = 1'b0;
    cycleN = 0;
    checkResetValues("after_reset");

    $display("[TB] directed: press, short release, full release");
    holdFrames('0, 1);
    holdFrames(k9, 5);
    holdFrames('0, 2);
    holdFrames(k9, 2);
    holdFrames('0, 3);

    $display("[TB] directed: bounce, simultaneous keys");
    holdFrames(k5, 2);
    holdFrames('0, 1);
    holdFrames(k5, 4);
    holdFrames('0, 3);
    holdFrames(k6and3, 4);
    holdFrames(16'h0001 << 3, 4);
    holdFrames('0, 3);

    $display("[TB] directed: reset while pressed");
    holdFrames(k9, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    cycleN = 0;
    checkResetValues("post_mid_reset");
    holdFrames(k9, 4);
    holdFrames('0, 3);

`ifdef KEYPAD_REPEAT_EN
    $display("[TB] directed: auto-repeat");
    holdFrames(k5, 3 + 8);
    holdFrames('0, 3);
`endif

    $display("[TB] random frames");
    prevMask = '0;
    for (int f = 0; f < 80; f++) begin
      case ($urandom_range(9, 0))
        0, 1, 2, 3, 4, 5: nextMask = prevMask;
        6:                nextMask = '0;
        7, 8:             nextMask = 16'h0001 << $urandom_range(15, 0);
        default:          nextMask = (16'h0001 << $urandom_range(15, 0)) |
                                     (16'h0001 << $urandom_range(15, 0));
      endcase
      applyStimulus(nextMask);
      prevMask = nextMask;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
